md_unit_ctrl: RTL
=================

# md_unit_ctrl

Multi-cycle multiply/divide sequencer with HI/LO register file, sitting in the E stage of the five-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and runs products and quotients over a fixed cycle count. It drives the `start_o`/`busy_o` pair that the D-stage stall logic uses to hold any md-class instruction in D while an operation is in flight. It also supports an E-stage flush that aborts an in-flight operation.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu; range 1..31
- DIV_CYCLES, 10, busy duration of div/divu; range 1..31

Ports. One clock; reset is asynchronous and active-low.
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- valid_i  in  1  E-stage instruction valid (not bubble, not stalled)
- op_i  in  4  encoding:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
  - 9–15 treated as none
- rs_i  in  32  forwarded rs operand
- rt_i  in  32  forwarded rt operand
- flush_i  in  1  E-stage flush (exception/interrupt); kills current E instruction and any in-flight op
- start_o  out  1  combinational; high when a mult/multu/div/divu issues this cycle
- busy_o  out  1  registered; high while an op is in flight
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO
- rd_o  out  32  combinational mf result: hi_o for mfhi, lo_o for mflo, else 0

## Operation
- Issue condition: `issue = valid_i & ~flush_i & ~busy_o`.
  - `start_o = issue & op in {1..4}`.
- At the issue edge:
  - latch rs_i and rt_i into operand registers;
  - latch the op kind;
  - load the 5-bit counter with MULT_CYCLES or DIV_CYCLES.
- State machine, two states:
  - IDLE (cnt==0): busy_o=0.
  - RUN (cnt!=0): busy_o=1; cnt decrements each cycle.
  - On the edge where cnt==1: write the computed result to HI/LO, cnt→0, return to IDLE.
- Arithmetic on latched operands, 64-bit product {HI,LO}:
  - mult: signed 32×32. multu: unsigned 32×32.
  - div: LO=signed quotient truncated toward zero; HI=remainder, sign of dividend.
  - divu: unsigned quotient and remainder.
- Division by zero (div and divu): LO=32'hFFFFFFFF, HI=dividend.
- Signed overflow (div, 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- mthi/mtlo: on an issue edge, HI or LO ← rs_i. Single-cycle; start_o stays 0; busy_o unaffected.
- mfhi/mflo: rd_o reflects the current register value combinationally. No state change.
- md op with valid_i=1 while busy_o=1: ignored, no state change.
  - This is a protocol violation because D-stage stall logic must prevent it; the bench asserts it never happens.
- flush_i=1:
  - any issue that cycle is suppressed, including start_o and mt writes;
  - if RUN, cnt→0 at that edge and HI/LO keep their pre-op values.
- Internal counter width is 5 bits; out-of-range parameters are an elaboration error.

## Timing
- Reset (rstn_i low, asynchronous): hi_o=0, lo_o=0, cnt=0, busy_o=0, operand registers 0.
  - start_o and rd_o follow inputs combinationally; rd_o=0 for non-mf ops.
- Issue in cycle T with latency L:
  - start_o=1 in T only;
  - busy_o=1 in cycles T+1 .. T+L (exactly L cycles);
  - new HI/LO visible from T+L+1, the same cycle busy_o returns to 0.
- Back-to-back: a second md op held in D may issue in T+L+1. mfhi in T+L+1 returns the new value.
- mthi/mtlo issued in T: new value visible on hi_o/lo_o in T+1.
- Flush in cycle F with T < F ≤ T+L: busy_o=0 from F+1 and HI/LO unchanged. A flush in cycle T itself is the same as no issue.
- Reset mid-RUN: immediate return to the reset values above; no partial write.
- rs_i and rt_i may change after T; the result depends only on the operands latched at T.

## Test plan
- mult with rs=0xFFFFFFFD, rt=7, default parameters:
  - start_o pulses in T; busy_o high T+1..T+5;
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB in T+6.
- multu with the same operands: HI=0x00000006, LO=0xFFFFFFEB; busy_o high for 5 cycles.
- div rs=0xFFFFFFF9 (−7), rt=2:
  - busy_o high 10 cycles;
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Repeat with rt=0 → LO=0xFFFFFFFF, HI=0xFFFFFFF9.
- mthi rs=0x12345678, then mfhi the next cycle:
  - hi_o and rd_o = 0x12345678;
  - start_o=0 and busy_o=0 throughout.
- divu issued with HI=LO=0xAAAAAAAA, flush_i at T+4:
  - busy_o=0 at T+5; HI and LO stay 0xAAAAAAAA.
  - A following mult issues normally at T+5.
- rstn_i low at T+2 of a mult: busy_o, hi_o and lo_o are 0 immediately. After release, an mflo returns 0.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide sequencer with the architectural HI/LO registers.
// Products and quotients are committed after a fixed busy window; a flush aborts the op with no write.
module md_unit_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        valid_i,
   input  logic [3:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic        flush_i,
   output logic        start_o,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [31:0] rd_o
);

   localparam int unsigned CW = 5;
   localparam int unsigned DW = 32;

   if (MULT_CYCLES == 0 || MULT_CYCLES > 31 || DIV_CYCLES == 0 || DIV_CYCLES > 31) begin : g_param_chk
      $error("md_unit_ctrl: MULT_CYCLES and DIV_CYCLES must be in 1..31");
   end

   typedef enum logic {S_IDLE, S_RUN} state_t;
   typedef enum logic [1:0] {K_MULT, K_MULTU, K_DIV, K_DIVU} kind_t;

   state_t         state;
   kind_t          kind;
   logic [CW-1:0]  cnt;
   logic [DW-1:0]  a_q, b_q;
   logic           issue, is_md, is_mult;
   logic [DW-1:0]  res_hi, res_lo;

   logic signed [DW-1:0]   sa, sb;
   logic signed [2*DW-1:0] prod_s;
   logic [2*DW-1:0]        prod_u;

   assign issue   = valid_i & ~flush_i & ~busy_o;
   assign is_md   = (op_i >= 4'd1) && (op_i <= 4'd4);
   assign is_mult = (op_i == 4'd1) || (op_i == 4'd2);
   assign start_o = issue & is_md;

   always_comb begin
      rd_o = '0;
      if (op_i == 4'd5)      rd_o = hi_o;
      else if (op_i == 4'd6) rd_o = lo_o;
   end

   assign sa     = signed'(a_q);
   assign sb     = signed'(b_q);
   assign prod_s = (2*DW)'(sa) * (2*DW)'(sb);
   assign prod_u = (2*DW)'(a_q) * (2*DW)'(b_q);

   // Result of the latched op; divide-by-zero and INT_MIN/-1 are pinned explicitly
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      case (kind)
         K_MULT: begin
            res_hi = prod_s[2*DW-1:DW];
            res_lo = prod_s[DW-1:0];
         end
         K_MULTU: begin
            res_hi = prod_u[2*DW-1:DW];
            res_lo = prod_u[DW-1:0];
         end
         K_DIV: begin
            if (b_q == '0) begin
               res_hi = a_q;
               res_lo = '1;
            end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
               res_hi = '0;
               res_lo = 32'h8000_0000;
            end else begin
               res_hi = sa % sb;
               res_lo = sa / sb;
            end
         end
         default: begin
            if (b_q == '0) begin
               res_hi = a_q;
               res_lo = '1;
            end else begin
               res_hi = a_q % b_q;
               res_lo = a_q / b_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state  <= S_IDLE;
         kind   <= K_MULT;
         cnt    <= '0;
         busy_o <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         hi_o   <= '0;
         lo_o   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_o) begin
                  a_q    <= rs_i;
                  b_q    <= rt_i;
                  kind   <= kind_t'(2'(op_i - 4'd1));
                  cnt    <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                  busy_o <= 1'b1;
                  state  <= S_RUN;
               end else if (issue && op_i == 4'd7) begin
                  hi_o <= rs_i;
               end else if (issue && op_i == 4'd8) begin
                  lo_o <= rs_i;
               end
            end
            default: begin
               // Flush wins over the final commit edge: HI/LO keep pre-op values
               if (flush_i) begin
                  cnt    <= '0;
                  busy_o <= 1'b0;
                  state  <= S_IDLE;
               end else if (cnt == CW'(1)) begin
                  hi_o   <= res_hi;
                  lo_o   <= res_lo;
                  cnt    <= '0;
                  busy_o <= 1'b0;
                  state  <= S_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
         endcase
      end
   end

endmodule
